alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of thread requesters sharing one ALU; legal range 2-8.
REQ-002 Parameter IDW, default $clog2(NUM_REQ): requester-id width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester operation valid.
REQ-006 req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a, req_b  in  NUM_REQ x 32  operand A/B per requester.
REQ-008 req_imm  in  NUM_REQ x 16  immediate per requester.
REQ-009 req_op  in  NUM_REQ x 3  ALU opcode per requester, using existing encoding (110 ADD, 111 AND, 101 OR, 011 XOR, 000 NOT, 001 SHLT, 010 SHRT, 100 SHAR).
REQ-010 req_itype  in  NUM_REQ  immediate-select per requester.
REQ-011 alu_a, alu_b  out  32  registered operands to the shared ALU.
REQ-012 alu_imm  out  16; alu_op  out  3; alu_itype  out  1  registered controls to the ALU.
REQ-013 alu_out  in  32; alu_eq, alu_lt, alu_ovf  in  1 each  combinational ALU results.
REQ-014 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-015 rsp_id  out  IDW; rsp_data  out  32; rsp_eq, rsp_lt, rsp_ovf  out  1 each  registered response.

Function
REQ-016 Two pipeline stages: S1 (issue register, drives alu_* ports), S2 (result register, drives rsp_* ports); each holds a valid bit and its requester id.
REQ-017 S2 loads from S1 when S1 is valid and (S2 is empty or rsp_valid & rsp_ready in the same cycle).
REQ-018 S1 may accept a new request when S1 is empty or S1 advances into S2 in that cycle.
REQ-019 Eligible requester: req_valid[i]=1 and in_flight[i]=0.
REQ-020 Grant is round-robin: the search starts at requester (last_grant+1) mod NUM_REQ; the first eligible requester wins.
REQ-021 req_ready[i] is high only for the winner, and only when S1 can accept; a transfer occurs when req_valid[i] & req_ready[i].
REQ-022 last_grant updates only on a completed transfer; it is unchanged otherwise.
REQ-023 in_flight[i] sets on transfer from i and clears on the rsp handshake with rsp_id=i.
REQ-024 If in_flight[i] is both set and cleared in the same cycle, it ends set.
REQ-025 Minimum latency is 2 cycles: a transfer at edge T gives rsp_valid=1 after edge T+1, with results equal to the ALU outputs for the S1 operands.
REQ-026 Under full throughput with distinct requesters, one response is produced per cycle.
REQ-027 While rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable.
REQ-028 While S1 is stalled, all alu_* outputs hold stable.
REQ-029 No combinational path exists from rsp_ready to any alu_* output; a path to req_ready is permitted.
REQ-030 Opcode, immediate and itype pass through unmodified; the arbiter does no arithmetic.
REQ-031 Operands and opcodes of invalid stages are don't-care, but their valid bits never assert spuriously.

Reset
REQ-032 On rst assertion (asynchronous), S1/S2 valid, in_flight, rsp_valid and req_ready are forced to 0.
REQ-033 On reset, last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-034 On reset, alu_*, rsp_data, rsp_id and the rsp flags reset to 0.
REQ-035 A reset mid-operation discards all in-flight operations; no response is produced for them after reset deasserts.
REQ-036 The first grant is possible on the first rising edge after rst deasserts.

Verification
REQ-037 Single op: req 2 issues ADD a=5, b=7, rsp_ready=1 -> rsp_valid two cycles later, rsp_id=2, rsp_data=12, eq=0, lt=1.
REQ-038 Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; one response per cycle after a 2-cycle fill.
REQ-039 One-outstanding limit: req 1 valid every cycle, rsp_ready=0 -> exactly one accept; req_ready[1] stays 0 until rsp handshake with id 1.
REQ-040 Backpressure: rsp_ready held 0 for 5 cycles with 3 requesters active -> S1 and S2 fill, req_ready all 0, rsp_* stable; release -> responses drain in grant order with no loss or duplication.
REQ-041 Simultaneous event: req 0 rsp handshake and new req 0 transfer in the same cycle -> transfer accepted and in_flight[0]=1 afterwards.
REQ-042 Reset mid-operation: rst pulsed with S1 and S2 valid -> rsp_valid=0 immediately; after release, req 0 is granted first and no stale response appears.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets NUM_REQ thread requesters share one combinational ALU
// through a two-stage issue/result pipeline, with at most one operation in flight per requester.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_a,
  input  logic [NUM_REQ-1:0][31:0]  req_b,
  input  logic [NUM_REQ-1:0][15:0]  req_imm,
  input  logic [NUM_REQ-1:0][2:0]   req_op,
  input  logic [NUM_REQ-1:0]        req_itype,
  output logic [31:0]               alu_a,
  output logic [31:0]               alu_b,
  output logic [15:0]               alu_imm,
  output logic [2:0]                alu_op,
  output logic                      alu_itype,
  input  logic [31:0]               alu_out,
  input  logic                      alu_eq,
  input  logic                      alu_lt,
  input  logic                      alu_ovf,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [31:0]               rsp_data,
  output logic                      rsp_eq,
  output logic                      rsp_lt,
  output logic                      rsp_ovf
);

  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]   NREQ     = (IDW + 1)'(NUM_REQ);

  logic                vld_p1;
  logic                vld_p2;
  logic [IDW-1:0]      id_p1;
  logic [NUM_REQ-1:0]  in_flight;
  logic [NUM_REQ-1:0]  rsp_clr;
  logic [NUM_REQ-1:0]  eligible;
  logic [IDW-1:0]      last_grant;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      cand;
  logic [IDW:0]        sum;
  logic                found;
  logic                rsp_fire;
  logic                adv_p1;
  logic                open_p1;
  logic                xfer;

  assign rsp_valid = vld_p2;
  assign rsp_fire  = vld_p2 & rsp_ready;
  assign adv_p1    = vld_p1 & (~vld_p2 | rsp_fire);
  assign open_p1   = ~vld_p1 | adv_p1;
  assign rsp_clr   = rsp_fire ? (NUM_REQ'(1) << rsp_id) : '0;

  // A requester whose response is being taken this cycle may already issue its next op.
  assign eligible  = req_valid & ~(in_flight & ~rsp_clr);

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_grant} + (IDW + 1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      cand = sum[IDW-1:0];
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign req_ready = (found && open_p1 && !rst) ? (NUM_REQ'(1) << win) : '0;
  assign xfer      = |req_ready;

  // Arbitration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight  <= '0;
      last_grant <= LAST_RST;
    end else begin
      in_flight <= (in_flight & ~rsp_clr) | req_ready;
      if (xfer) last_grant <= win;
    end
  end

  // S1: issue register feeding the shared ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_imm   <= '0;
      alu_op    <= '0;
      alu_itype <= 1'b0;
    end else if (xfer) begin
      vld_p1    <= 1'b1;
      id_p1     <= win;
      alu_a     <= req_a[win];
      alu_b     <= req_b[win];
      alu_imm   <= req_imm[win];
      alu_op    <= req_op[win];
      alu_itype <= req_itype[win];
    end else if (adv_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  // S2: result register holding the response until it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_eq   <= 1'b0;
      rsp_lt   <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (adv_p1) begin
      vld_p2   <= 1'b1;
      rsp_id   <= id_p1;
      rsp_data <= alu_out;
      rsp_eq   <= alu_eq;
      rsp_lt   <= alu_lt;
      rsp_ovf  <= alu_ovf;
    end else if (rsp_fire) begin
      vld_p2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an ALU stub, a transaction-level queue model of the arbiter,
// and directed plus randomized scenarios compared cycle by cycle against that model.
module tb_alu_arbiter;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][31:0] req_a;
  logic [N-1:0][31:0] req_b;
  logic [N-1:0][15:0] req_imm;
  logic [N-1:0][2:0]  req_op;
  logic [N-1:0]       req_itype;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [15:0]        alu_imm;
  logic [2:0]         alu_op;
  logic               alu_itype;
  logic [31:0]        alu_out;
  logic               alu_eq;
  logic               alu_lt;
  logic               alu_ovf;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_eq;
  logic               rsp_lt;
  logic               rsp_ovf;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm), .req_op(req_op), .req_itype(req_itype),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_op(alu_op), .alu_itype(alu_itype),
    .alu_out(alu_out), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        eq;
    logic        lt;
    logic        ovf;
  } res_t;

  function automatic res_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                   input logic [15:0] imm, input logic [2:0] op,
                                   input logic itype);
    logic [31:0] bb;
    logic [31:0] s;
    res_t r;
    bb    = itype ? {{16{imm[15]}}, imm} : b;
    s     = a + bb;
    r.ovf = 1'b0;
    case (op)
      3'b110: begin
        r.data = s;
        r.ovf  = (a[31] == bb[31]) && (s[31] != a[31]);
      end
      3'b111:  r.data = a & bb;
      3'b101:  r.data = a | bb;
      3'b011:  r.data = a ^ bb;
      3'b001:  r.data = a << bb[4:0];
      3'b010:  r.data = a >> bb[4:0];
      3'b100:  r.data = $signed(a) >>> bb[4:0];
      default: r.data = ~a;
    endcase
    r.eq = (a == bb);
    r.lt = ($signed(a) < $signed(bb));
    return r;
  endfunction

  assign {alu_out, alu_eq, alu_lt, alu_ovf} = alu_ref(alu_a, alu_b, alu_imm, alu_op, alu_itype);

  // Reference model: ordered list (at most two deep) of accepted operations plus a grant pointer.
  logic [1:0] m_n;
  logic [1:0] m_last;
  logic [1:0] m_id0, m_id1;
  res_t       m_res0, m_res1;
  int         m_t0, m_t1;
  int         m_cyc;

  logic       exp_rsp_valid, exp_fire, exp_found, exp_xfer;
  logic [N-1:0] exp_busy, exp_ready;
  logic [1:0] exp_win, cand;
  res_t       new_res;

  always_comb begin
    exp_rsp_valid = (m_n != 2'd0) && (m_cyc > m_t0);
    exp_fire      = exp_rsp_valid && rsp_ready;
    exp_busy      = '0;
    if (m_n != 2'd0 && !exp_fire) exp_busy[m_id0] = 1'b1;
    if (m_n == 2'd2) exp_busy[m_id1] = 1'b1;
    exp_found = 1'b0;
    exp_win   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= N; k++) begin
      cand = 2'((int'(m_last) + k) % N);
      if (!exp_found && req_valid[cand] && !exp_busy[cand]) begin
        exp_found = 1'b1;
        exp_win   = cand;
      end
    end
    exp_ready = '0;
    if (exp_found && (m_n != 2'd2 || exp_fire)) exp_ready[exp_win] = 1'b1;
    exp_xfer = |exp_ready;
    new_res  = alu_ref(req_a[exp_win], req_b[exp_win], req_imm[exp_win],
                       req_op[exp_win], req_itype[exp_win]);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n    <= 2'd0;
      m_last <= 2'(N - 1);
      m_cyc  <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (exp_xfer) m_last <= exp_win;
      if (exp_fire && exp_xfer) begin
        if (m_n == 2'd2) begin
          m_id0 <= m_id1; m_res0 <= m_res1; m_t0 <= m_t1;
          m_id1 <= exp_win; m_res1 <= new_res; m_t1 <= m_cyc + 1;
        end else begin
          m_id0 <= exp_win; m_res0 <= new_res; m_t0 <= m_cyc + 1;
        end
      end else if (exp_fire) begin
        m_id0 <= m_id1; m_res0 <= m_res1; m_t0 <= m_t1;
        m_n   <= m_n - 2'd1;
      end else if (exp_xfer) begin
        if (m_n == 2'd0) begin
          m_id0 <= exp_win; m_res0 <= new_res; m_t0 <= m_cyc + 1;
        end else begin
          m_id1 <= exp_win; m_res1 <= new_res; m_t1 <= m_cyc + 1;
        end
        m_n <= m_n + 2'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_imm   = {$urandom, $urandom};
    req_op    = 12'($urandom);
    req_itype = 4'($urandom);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    rand_ops();
    #3;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if ({alu_a, alu_b, alu_imm, alu_op, alu_itype} !== 84'd0) begin
      fails++; $display("FAIL reset_alu: got %h/%h/%h/%b expected zeros", alu_a, alu_b, alu_imm, alu_op); end
    tests++; if ({rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf} !== 37'd0) begin
      fails++; $display("FAIL reset_rsp: got id %0d data %h expected zeros", rsp_id, rsp_data); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    do_reset();
    rand_ops();
    req_a[2] = 32'd5; req_b[2] = 32'd7; req_op[2] = 3'b110; req_itype[2] = 1'b0;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b expected 0", rsp_valid); end
    tests++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 3'b110) begin
      fails++; $display("FAIL single_issue: got %0d %0d %b expected 5 7 110", alu_a, alu_b, alu_op); end
    tick();
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
    tests++; if ({rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf} !== {2'd2, 32'd12, 3'b010}) begin
      fails++; $display("FAIL single_rsp: got id %0d data %0d eq%b lt%b ovf%b expected id 2 data 12 eq0 lt1 ovf0",
                        rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf); end
    tick();
  endtask

  task automatic test_round_robin();
    int g = 0;
    int r = 0;
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      @(negedge clk);
      tests++; if (req_ready !== 4'(1 << (g % 4))) begin
        fails++; $display("FAIL rr_grant: cycle %0d got %b expected %b", i, req_ready, 4'(1 << (g % 4))); end
      if (req_ready != 4'b0000) g++;
      tests++; if (rsp_valid !== exp_rsp_valid) begin
        fails++; $display("FAIL rr_rsp_valid: cycle %0d got %b expected %b", i, rsp_valid, exp_rsp_valid); end
      if (rsp_valid && exp_rsp_valid) begin
        r++;
        tests++; if (rsp_id !== m_id0 || {rsp_data, rsp_eq, rsp_lt, rsp_ovf} !== m_res0) begin
          fails++; $display("FAIL rr_rsp: got id %0d data %h expected id %0d data %h", rsp_id, rsp_data, m_id0, m_res0.data); end
      end
      tick();
    end
    tests++; if (g !== 12) begin fails++; $display("FAIL rr_grant_count: got %0d expected 12", g); end
    tests++; if (r !== 10) begin fails++; $display("FAIL rr_rsp_count: got %0d expected 10", r); end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_one_outstanding();
    int acc = 0;
    do_reset();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      @(negedge clk);
      if (req_ready[1]) acc++;
      if (i > 0) begin
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL oneout_ready: cycle %0d got %b expected 0000", i, req_ready); end
      end
      tick();
    end
    tests++; if (acc !== 1) begin fails++; $display("FAIL oneout_accepts: got %0d expected 1", acc); end
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      fails++; $display("FAIL oneout_rsp: got valid %b id %0d expected valid 1 id 1", rsp_valid, rsp_id); end
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL oneout_reissue: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    logic [36:0] rsp_snap;
    logic [83:0] alu_snap;
    int got = 0;
    do_reset();
    req_valid = 4'b0111;
    rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rand_ops();
      @(negedge clk);
      tests++; if (req_ready !== exp_ready) begin
        fails++; $display("FAIL bp_ready: cycle %0d got %b expected %b", i, req_ready, exp_ready); end
      if (i == 2) begin
        rsp_snap = {rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf};
        alu_snap = {alu_a, alu_b, alu_imm, alu_op, alu_itype};
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_full: got %b expected 1", rsp_valid); end
      end else if (i > 2) begin
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_stall_ready: got %b expected 0000", req_ready); end
        tests++; if ({rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf} !== rsp_snap || rsp_valid !== 1'b1) begin
          fails++; $display("FAIL bp_rsp_hold: got %h expected %h", {rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf}, rsp_snap); end
        tests++; if ({alu_a, alu_b, alu_imm, alu_op, alu_itype} !== alu_snap) begin
          fails++; $display("FAIL bp_alu_hold: got %h expected %h", {alu_a, alu_b, alu_imm, alu_op, alu_itype}, alu_snap); end
      end
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      if (i == 4) req_valid = '0;
      @(negedge clk);
      tests++; if (req_ready !== exp_ready || rsp_valid !== exp_rsp_valid) begin
        fails++; $display("FAIL bp_drain: cycle %0d got %b/%b expected %b/%b", i, req_ready, rsp_valid, exp_ready, exp_rsp_valid); end
      if (rsp_valid && exp_rsp_valid) begin
        tests++; if (rsp_id !== m_id0 || {rsp_data, rsp_eq, rsp_lt, rsp_ovf} !== m_res0) begin
          fails++; $display("FAIL bp_drain_rsp: got id %0d data %h expected id %0d data %h", rsp_id, rsp_data, m_id0, m_res0.data); end
        if (got < 3) begin
          tests++; if (rsp_id !== 2'(got)) begin fails++; $display("FAIL bp_order: got id %0d expected %0d", rsp_id, got); end
          got++;
        end
      end
      tick();
    end
    tests++; if (got !== 3) begin fails++; $display("FAIL bp_count: got %0d expected 3", got); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rand_ops();
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL sim_first: got %b expected 0001", req_ready); end
    tick();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL sim_busy: got ready %b valid %b expected 0000 0", req_ready, rsp_valid); end
    tick();
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || req_ready !== 4'b0001) begin
      fails++; $display("FAIL sim_both: got valid %b id %0d ready %b expected 1 0 0001", rsp_valid, rsp_id, req_ready); end
    tick();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL sim_inflight: got %b expected 0000", req_ready); end
    tick();
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      fails++; $display("FAIL sim_second_rsp: got valid %b id %0d expected 1 0", rsp_valid, rsp_id); end
    tick();
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    repeat (2) begin rand_ops(); tick(); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_fill: got %b expected 1", rsp_valid); end
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL mid_async: got valid %b ready %b expected 0 0000", rsp_valid, req_ready); end
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++; if (rsp_valid !== exp_rsp_valid) begin
        fails++; $display("FAIL mid_stale: cycle %0d got %b expected %b", i, rsp_valid, exp_rsp_valid); end
      if (rsp_valid && exp_rsp_valid) begin
        tests++; if (rsp_id !== m_id0) begin fails++; $display("FAIL mid_rsp_id: got %0d expected %0d", rsp_id, m_id0); end
      end
      tick();
      rand_ops();
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [36:0] prev_rsp;
    logic        prev_stall = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      tests++; if (req_ready !== exp_ready) begin
        fails++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", i, req_ready, exp_ready); end
      tests++; if (rsp_valid !== exp_rsp_valid) begin
        fails++; $display("FAIL rnd_rsp_valid: cycle %0d got %b expected %b", i, rsp_valid, exp_rsp_valid); end
      if (rsp_valid && exp_rsp_valid) begin
        tests++; if (rsp_id !== m_id0 || {rsp_data, rsp_eq, rsp_lt, rsp_ovf} !== m_res0) begin
          fails++; $display("FAIL rnd_rsp: cycle %0d got id %0d res %h expected id %0d res %h",
                            i, rsp_id, {rsp_data, rsp_eq, rsp_lt, rsp_ovf}, m_id0, m_res0); end
      end
      if (prev_stall) begin
        tests++; if ({rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf} !== prev_rsp) begin
          fails++; $display("FAIL rnd_rsp_hold: cycle %0d got %h expected %h", i, {rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf}, prev_rsp); end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp   = {rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ovf};
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_one_outstanding();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
